// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin packet arbiter feeding a single UART TX FIFO.
//           Optional stall timeout enabled by macro UART_TX_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]             i_req_last,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic [NUM_REQ-1:0]             o_grant,
    input  logic                           i_tx_full,
    output logic                           o_write_uart,
    output logic [DATA_BITS-1:0]           o_write_data,
    output logic                           o_busy,
    output logic                           o_timeout_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ - 1);

    logic [0:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic [0:0]         w_state_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [IDX_W-1:0]   w_gidx_nxt;
    logic [IDX_W-1:0]   w_rr_nxt;
    logic [IDX_W-1:0]   w_gidx_inc;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_found;
    logic               w_accept;
    logic               w_timeout;

    // Accept is gated by reset so nothing reaches the FIFO while held in reset.
    assign w_accept   = (r_state == S_SEND) && i_req_valid[r_gidx] && !i_tx_full && i_rst_n;
    assign w_gidx_inc = (r_gidx == c_last_idx) ? '0 : r_gidx + IDX_W'(1);

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        int v_idx;
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            if (i_req[v_idx[IDX_W-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = v_idx[IDX_W-1:0];
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_timeout_err;
    logic             w_stall;

    assign w_stall   = (r_state == S_SEND) && !i_req_valid[r_gidx] && !i_tx_full;
    assign w_timeout = w_stall && (r_stall_cnt == c_cnt_max);

    // Held at zero throughout IDLE, so every SEND entry starts from zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if ((r_state == S_IDLE) || w_accept || w_timeout) begin
                r_stall_cnt <= '0;
            end else if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    assign w_timeout     = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt             = S_SEND;
                    w_grant_nxt             = '0;
                    w_grant_nxt[w_pick_idx] = 1'b1;
                    w_gidx_nxt              = w_pick_idx;
                end else begin
                    w_grant_nxt = '0;
                end
            end
            S_SEND: begin
                if ((w_accept && i_req_last[r_gidx]) || w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_rr_nxt    = w_gidx_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        o_write_uart = 1'b0;
        o_write_data = '0;
        o_req_ready  = '0;
        if (w_accept) begin
            o_write_uart = 1'b1;
            o_write_data = i_req_data[int'(r_gidx)*DATA_BITS +: DATA_BITS];
            o_req_ready  = r_grant;
        end
    end

    assign o_grant = r_grant;
    assign o_busy  = (r_state == S_SEND);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Directed and random checks of uart_tx_arbiter against a packet-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int TO = 8;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req, vld, lst;
    logic [N*DB-1:0] dat;
    logic            full;
    logic [N-1:0]    ready, grant;
    logic            wr;
    logic [DB-1:0]   wdata;
    logic            busy, terr;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .DATA_BITS      (DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstn),
        .i_req         (req),
        .i_req_valid   (vld),
        .i_req_data    (dat),
        .i_req_last    (lst),
        .o_req_ready   (ready),
        .o_grant       (grant),
        .i_tx_full     (full),
        .o_write_uart  (wr),
        .o_write_data  (wdata),
        .o_busy        (busy),
        .o_timeout_err (terr)
    );

    int checks = 0;
    int errors = 0;

    // Model: owner index (-1 = path free), round-robin pointer, stalls since last progress.
    int m_owner  = -1;
    int m_ptr    = 0;
    int m_stalls = 0;
    bit m_terr   = 1'b0;

    logic [DB-1:0] q_wr[$];
    logic [N-1:0]  g_log[$];
    logic          t_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_byte(input int r, input logic [DB-1:0] b);
        dat[r*DB +: DB] = b;
    endtask

    task automatic tick();
        logic          acc;
        logic [N-1:0]  one;
        logic [N-1:0]  eg;
        logic [DB-1:0] ed;
        bit            found;
        int            c;
        one = 1;
        #3;
        acc = 1'b0;
        eg  = '0;
        ed  = '0;
        if (m_owner >= 0) begin
            eg  = one << m_owner;
            acc = vld[m_owner] && !full && rstn;
            if (acc) ed = dat[m_owner*DB +: DB];
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("busy",  32'(busy),  32'(m_owner >= 0));
        chk("terr",  32'(terr),  32'(m_terr));
        chk("write", 32'(wr),    32'(acc));
        chk("wdata", 32'(wdata), 32'(ed));
        chk("ready", 32'(ready), acc ? 32'(eg) : 32'd0);
        g_log.push_back(grant);
        t_log.push_back(terr);
        if (wr) q_wr.push_back(wdata);

        if (!rstn) begin
            m_owner  = -1;
            m_ptr    = 0;
            m_stalls = 0;
            m_terr   = 1'b0;
        end else begin
            m_terr = 1'b0;
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (!found && req[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                    end
                end
                m_stalls = 0;
            end else if (acc) begin
                m_stalls = 0;
                if (lst[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end else if (!vld[m_owner] && !full) begin
                m_stalls++;
                if (TO_EN && m_stalls == TO) begin
                    m_terr   = 1'b1;
                    m_ptr    = (m_owner + 1) % N;
                    m_owner  = -1;
                    m_stalls = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DB-1:0] p3 [3];
        logic [DB-1:0] p4 [4];
        logic [N-1:0]  gseq [10];

        rstn = 1'b0; req = '0; vld = '0; lst = '0; dat = '0; full = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_terr",  32'(terr),  32'd0);

        // Three-byte packet from requester 0; Req drops after the grant.
        p3[0] = 8'hAA; p3[1] = 8'hBB; p3[2] = 8'hCC;
        rstn = 1'b1; req = 4'b0001; vld = 4'b0001; set_byte(0, p3[0]);
        q_wr.delete(); g_log.delete();
        tick();
        req = '0;
        for (int i = 0; i < 3; i++) begin
            set_byte(0, p3[i]);
            lst = (i == 2) ? 4'b0001 : 4'b0000;
            tick();
        end
        lst = '0; vld = '0;
        tick();
        chk("pkt3_len", 32'(q_wr.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("pkt3_byte", 32'(q_wr[i]), 32'(p3[i]));
        chk("pkt3_g0", 32'(g_log[0]), 32'd0);
        chk("pkt3_g1", 32'(g_log[1]), 32'd1);
        chk("pkt3_g3", 32'(g_log[3]), 32'd1);
        chk("pkt3_g4", 32'(g_log[4]), 32'd0);

        // All four requesting single-byte packets: round robin with an IDLE gap.
        rstn = 1'b0;
        tick();
        rstn = 1'b1; req = 4'hF; vld = 4'hF; lst = 4'hF; dat = 32'h44332211;
        g_log.delete();
        repeat (10) tick();
        gseq = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        for (int i = 0; i < 10; i++) chk("rr_seq", 32'(g_log[i]), 32'(gseq[i]));

        // TxFull held for five cycles in the middle of a four-byte packet.
        rstn = 1'b0; req = '0; vld = '0; lst = '0;
        tick();
        p4[0] = 8'h11; p4[1] = 8'h22; p4[2] = 8'h33; p4[3] = 8'h44;
        rstn = 1'b1; req = 4'b0010; vld = 4'b0010; set_byte(1, p4[0]);
        q_wr.delete();
        tick();
        tick();
        set_byte(1, p4[1]);
        tick();
        set_byte(1, p4[2]); full = 1'b1;
        repeat (5) tick();
        chk("full_hold", 32'(q_wr.size()), 32'd2);
        full = 1'b0;
        tick();
        set_byte(1, p4[3]); lst = 4'b0010;
        tick();
        lst = '0; vld = '0; req = '0;
        tick();
        chk("full_len", 32'(q_wr.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("full_byte", 32'(q_wr[i]), 32'(p4[i]));

        // Reset mid-packet from requester 2 after the pointer was moved past 0.
        rstn = 1'b0;
        tick();
        rstn = 1'b1; req = 4'b0001; vld = 4'b0001; lst = 4'b0001; set_byte(0, 8'h55);
        tick();
        tick();
        req = 4'b0100; vld = 4'b0100; lst = '0; set_byte(2, 8'h66);
        tick();
        tick();
        set_byte(2, 8'h77);
        tick();
        rstn = 1'b0;
        tick();
        chk("rst_mid_grant", 32'(grant), 32'd0);
        chk("rst_mid_busy",  32'(busy),  32'd0);
        rstn = 1'b1; req = 4'b0101; vld = 4'b0101;
        tick();
        chk("rst_next_grant", 32'(grant), 32'd1);
        lst = 4'b0101;
        tick();
        req = '0; vld = '0; lst = '0;
        tick();
        tick();

        // Granted requester 0 stops presenting data after one byte.
        rstn = 1'b0;
        tick();
        rstn = 1'b1; req = 4'b0011; vld = 4'b0011; lst = '0; dat = 32'h0000_BB_AA;
        tick();
        tick();
        vld = 4'b0010;
        g_log.delete(); t_log.delete();
        repeat (20) tick();
        for (int j = 0; j < 20; j++) begin
            if (TO_EN) chk("to_pulse", 32'(t_log[j]), 32'(j == 8));
            else       chk("to_none",  32'(t_log[j]), 32'd0);
        end
        if (TO_EN) begin
            chk("to_idle",  32'(g_log[8]), 32'd0);
            chk("to_grant", 32'(g_log[9]), 32'd2);
        end else begin
            chk("hold_grant", 32'(g_log[19]), 32'd1);
        end

        // Random traffic against the model.
        rstn = 1'b0; req = '0; vld = '0; lst = '0;
        tick();
        for (int n = 0; n < 3000; n++) begin
            req  = N'($urandom);
            vld  = N'($urandom | $urandom);
            lst  = N'($urandom & $urandom);
            dat  = $urandom;
            full = ($urandom_range(0, 4) == 0);
            rstn = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the UART transmit path.
REQ-002 Parameter DATA_BITS, default 8: byte width, equal to the UART DATA_BITS.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: stall limit in clocks for a granted requester.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 ResetN  input  1  reset, synchronous and active-low.
REQ-006 Req  input  NUM_REQ  bit i high means requester i has a packet pending.
REQ-007 ReqValid  input  NUM_REQ  bit i high means ReqData slice i holds a valid byte.
REQ-008 ReqData  input  NUM_REQ*DATA_BITS  flattened bytes; slice i is bits [i*DATA_BITS +: DATA_BITS].
REQ-009 ReqLast  input  NUM_REQ  bit i high marks the last byte of the packet from requester i.
REQ-010 ReqReady  output  NUM_REQ  bit i high means the byte from requester i is accepted this cycle.
REQ-011 Grant  output  NUM_REQ  one-hot owner of the transmit path, or all zeros.
REQ-012 TxFull  input  1  UART TX FIFO full flag.
REQ-013 WriteUart  output  1  write strobe to the UART TX FIFO.
REQ-014 WriteData  output  DATA_BITS  byte to the UART TX FIFO.
REQ-015 Busy  output  1  high while a packet owns the path.
REQ-016 TimeoutErr  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-017 The FSM SHALL have two states, IDLE and SEND; Busy SHALL equal (state==SEND) and be registered.
REQ-018 In IDLE with any Req bit set, next cycle: state=SEND; Grant=first set Req bit found searching upward from RrPtr, wrapping modulo NUM_REQ.
REQ-019 In IDLE with Req all zero: stay IDLE, Grant=0.
REQ-020 Grant SHALL be registered and held constant for the whole SEND state.
REQ-021 Accept (combinational, zero latency) = SEND & ReqValid[g] & ~TxFull, where g is the granted index.
REQ-022 When Accept is high: WriteUart=1, WriteData=ReqData slice g, ReqReady[g]=1; otherwise WriteUart=0 and ReqReady=0.
REQ-023 ReqReady bits other than g SHALL always be 0; WriteUart SHALL never be high while TxFull is high.
REQ-024 When WriteUart is low, WriteData SHALL be 0.
REQ-025 Accept together with ReqLast[g]: next cycle state=IDLE, Grant=0, RrPtr=(g+1) mod NUM_REQ.
REQ-026 Consecutive packets therefore have exactly one IDLE cycle between them.
REQ-027 Deassertion of Req[g] during SEND SHALL be ignored; the grant holds until the last byte or a timeout.
REQ-028 ReqValid from non-granted requesters SHALL have no effect.
REQ-029 Cycles in SEND with TxFull high SHALL never count as stalls.

Reset
REQ-030 ResetN low at a rising edge: state=IDLE, Grant=0, RrPtr=0, Busy=0, TimeoutErr=0, stall counter=0.
REQ-031 While ResetN is low, WriteUart=0, WriteData=0 and ReqReady=0.
REQ-032 Reset during SEND SHALL abandon the partial packet; no further bytes are written.

Configuration
REQ-033 Macro UART_TX_ARB_TIMEOUT_EN: when defined, a stall counter SHALL count SEND cycles with ~ReqValid[g] & ~TxFull.
REQ-034 The stall counter SHALL clear on every Accept and on entry to SEND.
REQ-035 When the counter reaches TIMEOUT_CYCLES-1 and another stall occurs: next cycle state=IDLE, Grant=0, RrPtr=(g+1) mod NUM_REQ, TimeoutErr=1 for one cycle.
REQ-036 When the macro is undefined: no counter is built, TimeoutErr is tied to 0, and the grant waits indefinitely.

Verification
REQ-037 Req=0001; a 3-byte packet 0xAA,0xBB,0xCC with ReqValid held high and TxFull=0 -> WriteUart high on 3 consecutive cycles with those bytes; Grant=0001 then 0000.
REQ-038 Req=1111 held after reset -> Grant sequence 0001,0010,0100,1000,0001, with one IDLE cycle between packets.
REQ-039 TxFull=1 for 5 cycles mid-packet -> WriteUart=0 and ReqReady=0 during those cycles; no byte lost or duplicated; the same byte is written when TxFull falls.
REQ-040 ResetN low for 1 cycle after the second of 4 bytes from requester 2 -> Grant=0, Busy=0; the next grant goes to the lowest pending requester, starting from index 0.
REQ-041 Macro defined, TIMEOUT_CYCLES=8, granted requester drops ReqValid -> TimeoutErr pulses 8 cycles after the last accept and the grant moves to the next pending requester; macro undefined -> the grant is held indefinitely and TimeoutErr stays 0.
